apb_master_bridge: RTL and testbench

APB initiator between the pipelined core's memory stage and the peripheral bus. It converts one core load/store request into a two-phase APB transfer (SETUP, then ACCESS) and stalls the core until the transfer completes. It returns read data, a one-cycle completion pulse, and an error flag for out-of-range addresses or a timeout. Its APB outputs drive the address decoder, which routes PSEL to UART and future peripherals.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge.sv | 170 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge.
//   apb_state_t      : bridge FSM state encoding
//   APB_BASE_HI      : address bits [31:16] that map an access onto APB
//   UART_OFFSET      : UART select code carried in address bits [11:8]
//   PERIPH_SEL_LSB   : low bit of the peripheral select field
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

  localparam logic [15:0] APB_BASE_HI    = 16'h2000;
  localparam logic [3:0]  UART_OFFSET    = 4'h0;
  localparam int unsigned PERIPH_SEL_LSB = 8;

endpackage

// File: rtl/apb_master_bridge.sv
// APB initiator for the core memory stage. Turns one load/store request into
// an APB SETUP/ACCESS transfer, stalls the core meanwhile, and returns read
// data with a one-cycle completion pulse and an error flag.
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   mem_req/write/addr/wdata/strb : core request (held while mem_stall=1)
//   mem_stall                  : core pipeline freeze
//   mem_rdata, resp_valid, resp_err : completion (data valid with resp_valid)
//   PADDR/PWDATA/PSTRB/PWRITE/PSEL/PENABLE : APB request outputs
//   PRDATA, PREADY             : APB slave response
//
// state  | meaning
// IDLE   | waiting for a request; out-of-range requests go straight to DONE
// SETUP  | APB setup phase, PSEL=1 PENABLE=0, timeout counter cleared
// ACCESS | APB access phase, waiting for PREADY or timeout
// DONE   | one-cycle completion pulse, no new request accepted
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter logic [15:0] BASE_HI        = APB_BASE_HI,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_strb,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [1:0]  PSTRB,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [1:0]        pstrb_q, pstrb_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  // All registered outputs describe the state being entered, so the
  // next-state logic also sets the outputs for that state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pwrite_d     = pwrite_q;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    rdata_d      = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (mem_addr[31:16] == BASE_HI) begin
            paddr_d  = mem_addr;
            pwdata_d = mem_wdata;
            pstrb_d  = mem_strb;
            pwrite_d = mem_write;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = DONE;
          end
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over the timeout when both land in the same cycle.
        if (PREADY) begin
          rdata_d      = pwrite_q ? 32'd0 : PRDATA;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = DONE;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The stall must cover the request cycle itself, so it is combinational
  // on mem_req while idle.
  always_comb begin
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE:          mem_stall = mem_req;
      SETUP, ACCESS: mem_stall = 1'b1;
      default:       mem_stall = 1'b0;
    endcase
  end

  assign mem_rdata  = rdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign PWRITE     = pwrite_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: the driver pushes the expected
// completion for each request, a monitor pops and compares on resp_valid and
// watches the APB bus, and a slave model answers with chosen wait states.
module tb_apb_master_bridge;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          req_cyc;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_strb;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_err;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [1:0]  PSTRB;
  logic        PWRITE, PSEL, PENABLE, PREADY;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t sb[$];

  // Current request as seen by the monitor and the slave model.
  logic [31:0] cur_addr, cur_wdata, cur_prdata;
  logic [1:0]  cur_strb;
  logic        cur_write, cur_oor;
  int          cur_waits;

  apb_master_bridge #(.BASE_HI(16'h2000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_paddr"},   PADDR, 32'd0);
    chk({tag, "_pwdata"},  PWDATA, 32'd0);
    chk({tag, "_pstrb"},   32'(PSTRB), 32'd0);
    chk({tag, "_pwrite"},  32'(PWRITE), 32'd0);
    chk({tag, "_psel"},    32'(PSEL), 32'd0);
    chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
    chk({tag, "_rdata"},   mem_rdata, 32'd0);
    chk({tag, "_rvalid"},  32'(resp_valid), 32'd0);
    chk({tag, "_rerr"},    32'(resp_err), 32'd0);
  endtask

  // Slave: answers PREADY on the ACCESS cycle whose index equals cur_waits;
  // outside ACCESS PREADY and PRDATA are random noise the bridge must ignore.
  initial begin
    int k;
    k = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    forever begin
      @(posedge clk);
      #1;
      if (PSEL && PENABLE) begin
        PREADY = (k == cur_waits);
        PRDATA = (k == cur_waits) ? cur_prdata : $urandom;
        k++;
      end else begin
        k = 0;
        PREADY = 1'($urandom);
        PRDATA = $urandom;
      end
    end
  end

  // Monitor: bus protocol checks every cycle, scoreboard pop on resp_valid.
  initial begin
    int acc;
    logic prev_psel;
    exp_t e;
    acc = 0;
    prev_psel = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        acc = 0;
        prev_psel = 1'b0;
        continue;
      end
      chk("stall", 32'(mem_stall), 32'(mem_req && !resp_valid));
      if (PENABLE) begin
        acc++;
        chk("penable_needs_psel", 32'(PSEL), 32'd1);
      end
      if (PSEL) begin
        if (!prev_psel) chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("psel_in_range", 32'(cur_oor), 32'd0);
        chk("paddr", PADDR, cur_addr);
        chk("pwdata", PWDATA, cur_wdata);
        chk("pstrb", 32'(PSTRB), 32'(cur_strb));
        chk("pwrite", 32'(PWRITE), 32'(cur_write));
      end
      prev_psel = PSEL;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("rdata", mem_rdata, e.rdata);
          chk("err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
          chk("access_cycles", 32'(acc), 32'(e.acc));
        end
        acc = 0;
      end
    end
  end

  // Reference model: outcome of one request from the address map, the slave
  // wait count and the timeout limit.
  function automatic exp_t model(input logic w, input logic [31:0] a, input int waits,
                                 input logic [31:0] prd, input int req_cyc);
    exp_t e;
    e.req_cyc = req_cyc;
    if (a[31:16] != 16'h2000) begin
      e.lat = 1; e.acc = 0; e.err = 1'b1; e.rdata = 32'd0;
    end else if (waits >= TMO) begin
      e.lat = 2 + TMO; e.acc = TMO; e.err = 1'b1; e.rdata = 32'd0;
    end else begin
      e.lat = 3 + waits; e.acc = waits + 1; e.err = 1'b0;
      e.rdata = w ? 32'd0 : prd;
    end
    return e;
  endfunction

  task automatic wait_resp(output bit ok);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 60);
    ok = resp_valid;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles expected one", n);
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] st, input int waits, input logic [31:0] prd,
                        input bit hold);
    bit ok;
    @(posedge clk);
    #1;
    cur_addr = a; cur_wdata = wd; cur_strb = st; cur_write = w;
    cur_oor = (a[31:16] != 16'h2000);
    cur_waits = waits; cur_prdata = prd;
    mem_req = 1'b1; mem_write = w; mem_addr = a; mem_wdata = wd; mem_strb = st;
    sb.push_back(model(w, a, waits, prd, cyc));
    wait_resp(ok);
    if (ok && hold) begin
      // Request stays up through DONE: it must only be taken in the next IDLE.
      sb.push_back(model(w, a, waits, prd, cyc + 1));
      chk("b2b_done_psel", 32'(PSEL), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_idle_psel", 32'(PSEL), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_setup_psel", 32'(PSEL), 32'd1);
      chk("b2b_setup_penable", 32'(PENABLE), 32'd0);
      wait_resp(ok);
    end
    mem_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] hi;
    int r, waits;
    rst = 1'b1;
    mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
    cur_addr = '0; cur_wdata = '0; cur_strb = '0; cur_write = 1'b0; cur_oor = 1'b0;
    cur_waits = 0; cur_prdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;

    // Directed cases.
    do_txn(1'b1, 32'h2000_0004, 32'hA5A5_0001, 2'b10, 0, 32'h0, 1'b0);
    do_txn(1'b0, 32'h2000_0000, 32'h0, 2'b00, 3, 32'h0000_0041, 1'b0);
    do_txn(1'b0, 32'h1000_0000, 32'h1234_5678, 2'b01, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 32'h2000_0100, 32'h0, 2'b11, 999, 32'hFFFF_FFFF, 1'b0);
    do_txn(1'b0, 32'h2000_0108, 32'h0, 2'b01, TMO - 1, 32'h0BAD_F00D, 1'b0);

    // Reset during the second ACCESS cycle: no response may follow.
    @(posedge clk);
    #1;
    cur_addr = 32'h2000_0010; cur_wdata = 32'h55AA_55AA; cur_strb = 2'b11;
    cur_write = 1'b0; cur_oor = 1'b0; cur_waits = 1000; cur_prdata = '0;
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = cur_addr;
    mem_wdata = cur_wdata; mem_strb = cur_strb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_penable", 32'(PENABLE), 32'd1);
    rst = 1'b1;
    mem_req = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid");
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    do_txn(1'b1, 32'h2000_0020, 32'hCAFE_0002, 2'b01, 1, 32'h0, 1'b0);

    // Back-to-back with mem_req held high.
    do_txn(1'b1, 32'h2000_0030, 32'h0000_BEEF, 2'b10, 0, 32'h0, 1'b1);
    do_txn(1'b0, 32'h2000_0034, 32'h0, 2'b00, 2, 32'h7777_1234, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        a = {16'h2000, 16'($urandom)};
      end else begin
        hi = 16'($urandom);
        if (hi == 16'h2000) hi = 16'h1000;
        a = {hi, 16'($urandom)};
      end
      r = $urandom_range(0, 9);
      if (r < 6)      waits = $urandom_range(0, 3);
      else if (r < 8) waits = $urandom_range(10, TMO - 1);
      else            waits = $urandom_range(TMO, TMO + 4);
      do_txn(1'($urandom), a, $urandom, 2'($urandom), waits, $urandom,
             $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending responses expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
